// File: rtl/lr_predict_scheduler.sv
// rtl/lr_predict_scheduler.sv - round-robin scheduler sharing one linear-regression predictor between two requesters
module lr_predict_scheduler #(
    parameter int N       = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [N-1:0]     i_theta0_in,
    input  logic [N-1:0]     i_theta1_in,
    input  logic             i_model_load,
    input  logic [N-1:0]     i_req0_x,
    input  logic [N-1:0]     i_req1_x,
    input  logic             i_req0_vld,
    input  logic             i_req1_vld,
    output logic             o_req0_rdy,
    output logic             o_req1_rdy,
    output logic [N-1:0]     o_samples_x_in,
    output logic             o_samples_x_vld,
    output logic [N-1:0]     o_theta0_out,
    output logic [N-1:0]     o_theta1_out,
    output logic             o_theta1_out_vld,
    input  logic [N-1:0]     i_predict_out,
    input  logic             i_predict_out_vld,
    output logic [N-1:0]     o_result,
    output logic             o_result_id,
    output logic             o_result_vld,
    input  logic             i_result_rdy,
    output logic             o_error,
    output logic [CNT_W-1:0] o_pred_count
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {NOMODEL, IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t          state;
    logic [N-1:0]    shadow0;
    logic [N-1:0]    shadow1;
    logic            pending;
    logic            id_q;
    logic            rr;
    logic            issue_vld;
    logic [TW-1:0]   wait_cnt;
    logic            load_now;
    logic            gnt0;
    logic            gnt1;

    assign load_now = i_model_load | pending;

    // Model updates pre-empt grants; rr names the preferred requester when both are valid.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE && !load_now) begin
            if (i_req0_vld && (!rr || !i_req1_vld))
                gnt0 = 1'b1;
            else if (i_req1_vld)
                gnt1 = 1'b1;
        end
    end

    assign o_req0_rdy       = gnt0;
    assign o_req1_rdy       = gnt1;
    assign o_samples_x_vld  = issue_vld;
    assign o_theta1_out_vld = issue_vld;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state          <= NOMODEL;
            shadow0        <= '0;
            shadow1        <= '0;
            pending        <= 1'b0;
            id_q           <= 1'b0;
            rr             <= 1'b0;
            issue_vld      <= 1'b0;
            wait_cnt       <= '0;
            o_samples_x_in <= '0;
            o_theta0_out   <= '0;
            o_theta1_out   <= '0;
            o_result       <= '0;
            o_result_id    <= 1'b0;
            o_result_vld   <= 1'b0;
            o_error        <= 1'b0;
            o_pred_count   <= '0;
        end else begin
            case (state)
                NOMODEL: begin
                    if (i_model_load) begin
                        o_theta0_out <= i_theta0_in;
                        o_theta1_out <= i_theta1_in;
                        state        <= IDLE;
                    end
                end
                IDLE: begin
                    if (i_model_load) begin
                        o_theta0_out <= i_theta0_in;
                        o_theta1_out <= i_theta1_in;
                        pending      <= 1'b0;
                    end else if (pending) begin
                        o_theta0_out <= shadow0;
                        o_theta1_out <= shadow1;
                        pending      <= 1'b0;
                    end else if (gnt0 || gnt1) begin
                        o_samples_x_in <= gnt1 ? i_req1_x : i_req0_x;
                        id_q           <= gnt1;
                        issue_vld      <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    issue_vld <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (i_predict_out_vld) begin
                        o_result     <= i_predict_out;
                        o_result_id  <= id_q;
                        o_result_vld <= 1'b1;
                        state        <= HOLD;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        o_error <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                HOLD: begin
                    if (i_result_rdy) begin
                        o_result_vld <= 1'b0;
                        o_pred_count <= o_pred_count + CNT_W'(1);
                        rr           <= ~id_q;
                        state        <= IDLE;
                    end
                end
                default: state <= NOMODEL;
            endcase

            // A load arriving while a sample is in flight is deferred so that sample keeps the old model.
            if (i_model_load && (state == ISSUE || state == WAIT || state == HOLD)) begin
                shadow0 <= i_theta0_in;
                shadow1 <= i_theta1_in;
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lr_predict_scheduler.sv
// tb/tb_lr_predict_scheduler.sv - directed self-checking bench for lr_predict_scheduler
module tb_lr_predict_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] theta0_in, theta1_in;
    logic        model_load;
    logic [31:0] req0_x, req1_x;
    logic        req0_vld, req1_vld;
    logic        req0_rdy, req1_rdy;
    logic [31:0] samples_x_in;
    logic        samples_x_vld;
    logic [31:0] theta0_out, theta1_out;
    logic        theta1_out_vld;
    logic [31:0] predict_out;
    logic        predict_out_vld;
    logic [31:0] result;
    logic        result_id;
    logic        result_vld;
    logic        result_rdy;
    logic        error;
    logic [15:0] pred_count;
    logic        pred_kill;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    lr_predict_scheduler #(.N(32), .TIMEOUT(16), .CNT_W(16)) dut (
        .i_clock(clk), .i_reset(rst_n),
        .i_theta0_in(theta0_in), .i_theta1_in(theta1_in), .i_model_load(model_load),
        .i_req0_x(req0_x), .i_req1_x(req1_x), .i_req0_vld(req0_vld), .i_req1_vld(req1_vld),
        .o_req0_rdy(req0_rdy), .o_req1_rdy(req1_rdy),
        .o_samples_x_in(samples_x_in), .o_samples_x_vld(samples_x_vld),
        .o_theta0_out(theta0_out), .o_theta1_out(theta1_out), .o_theta1_out_vld(theta1_out_vld),
        .i_predict_out(predict_out), .i_predict_out_vld(predict_out_vld),
        .o_result(result), .o_result_id(result_id), .o_result_vld(result_vld),
        .i_result_rdy(result_rdy), .o_error(error), .o_pred_count(pred_count)
    );

    // One-cycle registered predictor: y = theta1*x + theta0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            predict_out     <= '0;
            predict_out_vld <= 1'b0;
        end else begin
            predict_out     <= theta1_out * samples_x_in + theta0_out;
            predict_out_vld <= samples_x_vld & theta1_out_vld & ~pred_kill;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic load(input logic [31:0] t0, input logic [31:0] t1);
        theta0_in  = t0;
        theta1_in  = t1;
        model_load = 1'b1;
        step();
        model_load = 1'b0;
    endtask

    // Drops each request after its handshake; returns once a result is presented.
    task automatic get_result(output logic [31:0] r, output logic id);
        bit ok = 0;
        bit hs0, hs1;
        r  = '0;
        id = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            hs0 = req0_vld & req0_rdy;
            hs1 = req1_vld & req1_rdy;
            @(posedge clk);
            #1;
            if (hs0) req0_vld = 1'b0;
            if (hs1) req1_vld = 1'b0;
            if (result_vld) begin
                r  = result;
                id = result_id;
                ok = 1;
            end
        end
        check_eq("result_arrived", 32'(ok), 32'd1);
    endtask

    logic [31:0] r;
    logic        id;
    int          n;
    bit          seen_vld;

    initial begin
        rst_n = 1'b0; theta0_in = '0; theta1_in = '0; model_load = 1'b0;
        req0_x = '0; req1_x = '0; req0_vld = 1'b0; req1_vld = 1'b0;
        result_rdy = 1'b1; pred_kill = 1'b0;
        step();
        step();
        check_eq("rst_error", 32'(error), 0);
        check_eq("rst_count", 32'(pred_count), 0);
        check_eq("rst_result_vld", 32'(result_vld), 0);
        check_eq("rst_theta1", theta1_out, 0);
        check_eq("rst_samples_vld", 32'(samples_x_vld), 0);
        rst_n = 1'b1;
        step();

        // No model loaded: requests must not be accepted.
        req0_vld = 1'b1; req0_x = 32'd4;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("nomodel_rdy0", 32'(req0_rdy), 0);
            check_eq("nomodel_xvld", 32'(samples_x_vld), 0);
            step();
        end
        req0_vld = 1'b0;

        // Basic latency: 3*4+5 = 17.
        load(32'd5, 32'd3);
        req0_x = 32'd4; req0_vld = 1'b1;
        #1 check_eq("t0_rdy0", 32'(req0_rdy), 1);
        @(posedge clk); #1;
        req0_vld = 1'b0;
        check_eq("t1_xvld", 32'(samples_x_vld), 1);
        check_eq("t1_thvld", 32'(theta1_out_vld), 1);
        check_eq("t1_x", samples_x_in, 4);
        check_eq("t1_theta0", theta0_out, 5);
        step();
        check_eq("t2_xvld", 32'(samples_x_vld), 0);
        check_eq("t2_rvld", 32'(result_vld), 0);
        step();
        check_eq("t3_rvld", 32'(result_vld), 1);
        check_eq("t3_result", result, 17);
        check_eq("t3_id", 32'(result_id), 0);
        step();
        check_eq("t4_count", 32'(pred_count), 1);
        check_eq("t4_rvld", 32'(result_vld), 0);

        // Round-robin with both requesters valid.
        do_reset();
        load(32'd0, 32'd10);
        for (int k = 0; k < 2; k++) begin
            req0_x = 32'd1; req1_x = 32'd2; req0_vld = 1'b1; req1_vld = 1'b1;
            get_result(r, id);
            check_eq("rr_first_id", 32'(id), 0);
            check_eq("rr_first_res", r, 10);
            step();
            get_result(r, id);
            check_eq("rr_second_id", 32'(id), 1);
            check_eq("rr_second_res", r, 20);
            step();
        end
        check_eq("rr_count", 32'(pred_count), 4);

        // Result backpressure.
        result_rdy = 1'b0;
        req0_x = 32'd3; req0_vld = 1'b1;
        get_result(r, id);
        check_eq("bp_res", r, 30);
        req1_x = 32'd7; req1_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_stable", result, 30);
            check_eq("bp_vld", 32'(result_vld), 1);
            check_eq("bp_rdy0", 32'(req0_rdy), 0);
            check_eq("bp_rdy1", 32'(req1_rdy), 0);
            step();
        end
        result_rdy = 1'b1;
        step();
        check_eq("bp_count", 32'(pred_count), 5);
        check_eq("bp_vld_clr", 32'(result_vld), 0);
        get_result(r, id);
        check_eq("bp_next_id", 32'(id), 1);
        check_eq("bp_next_res", r, 70);
        step();
        check_eq("bp_count2", 32'(pred_count), 6);

        // Model load while a sample is in flight.
        do_reset();
        load(32'd0, 32'd3);
        req0_x = 32'd5; req0_vld = 1'b1;
        #1 check_eq("ld_rdy0", 32'(req0_rdy), 1);
        @(posedge clk); #1;
        req0_vld = 1'b0;
        step();
        theta1_in = 32'd2; theta0_in = 32'd0; model_load = 1'b1;
        step();
        model_load = 1'b0;
        #1;
        check_eq("ld_old_theta1", theta1_out, 3);
        check_eq("ld_old_vld", 32'(result_vld), 1);
        check_eq("ld_old_res", result, 15);
        step();
        req0_vld = 1'b1;
        #1 check_eq("ld_pending_rdy0", 32'(req0_rdy), 0);
        step();
        check_eq("ld_new_theta1", theta1_out, 2);
        get_result(r, id);
        check_eq("ld_new_res", r, 10);
        step();

        // Predictor timeout, then reset while waiting.
        pred_kill = 1'b1;
        req0_x = 32'd1; req0_vld = 1'b1;
        #1 check_eq("to_rdy0", 32'(req0_rdy), 1);
        @(posedge clk); #1;
        req0_vld = 1'b0;
        n = 1;
        seen_vld = 0;
        while (!error && n < 40) begin
            step();
            n++;
            seen_vld |= result_vld;
        end
        check_eq("to_cycles", n, 18);
        check_eq("to_no_result", 32'(seen_vld), 0);
        check_eq("to_error", 32'(error), 1);
        req0_vld = 1'b1;
        #1 check_eq("to_idle_rdy0", 32'(req0_rdy), 1);
        @(posedge clk); #1;
        req0_vld = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check_eq("mr_error", 32'(error), 0);
        check_eq("mr_count", 32'(pred_count), 0);
        check_eq("mr_theta0", theta0_out, 0);
        check_eq("mr_theta1", theta1_out, 0);
        check_eq("mr_xvld", 32'(samples_x_vld), 0);
        check_eq("mr_rvld", 32'(result_vld), 0);
        rst_n = 1'b1;
        req0_vld = 1'b1;
        step();
        check_eq("mr_nomodel_rdy0", 32'(req0_rdy), 0);
        req0_vld = 1'b0;
        pred_kill = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
